// File: rtl/mux_4to1_lut_pkg.sv
// -----------------------------------------------------------------------------
// mux_4to1_lut_pkg
// Shared widths and the default table contents for the reconfigurable 4:1
// single-bit mux. The table is indexed by {sel, d}: addr[5:4] = sel,
// addr[3:0] = d. The default entry at {s, dd} holds dd[s], so an
// unprogrammed table behaves as a plain 4:1 mux.
// -----------------------------------------------------------------------------
package mux_4to1_lut_pkg;

  localparam int SEL_W       = 2;
  localparam int DATA_W      = 4;
  localparam int ADDR_W      = SEL_W + DATA_W;
  localparam int LUT_ENTRIES = 1 << ADDR_W;

  // Default value of one table entry: the data bit chosen by the select field.
  function automatic logic default_lut_bit(input logic [ADDR_W-1:0] addr);
    return addr[addr[ADDR_W-1:DATA_W]];
  endfunction

  function automatic logic [LUT_ENTRIES-1:0] build_default_lut();
    logic [LUT_ENTRIES-1:0] v;
    v = '0;
    for (int i = 0; i < LUT_ENTRIES; i++) begin
      v[i] = default_lut_bit(ADDR_W'(i));
    end
    return v;
  endfunction

  // Full default table, also loaded on reset and on restore.
  localparam logic [LUT_ENTRIES-1:0] DEFAULT_LUT = build_default_lut();

endpackage

// File: rtl/mux_4to1_lut_if.sv
// -----------------------------------------------------------------------------
// mux_4to1_lut_if
// Bundles the data path (d, sel -> out, out_q) and the configuration port
// (cfg_we, cfg_addr, cfg_wdata, cfg_restore -> cfg_dirty) of mux_4to1_lut.
//
// Signalling: there is no valid/ready handshake. cfg_we and cfg_restore are
// single-cycle strobes sampled on the rising clock edge; the block is always
// ready, so every strobe seen while rst_n=1 takes effect on that edge.
// cfg_restore has priority over cfg_we when both are high.
//
// Modports:
//   master - drives d, sel and the cfg_* requests; observes out/out_q/dirty
//   slave  - the mux_4to1_lut block itself
// -----------------------------------------------------------------------------
interface mux_4to1_lut_if;
  import mux_4to1_lut_pkg::*;

  logic [DATA_W-1:0] d;
  logic [SEL_W-1:0]  sel;
  logic              out;
  logic              out_q;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cfg_wdata;
  logic              cfg_restore;
  logic              cfg_dirty;

  modport master (
    output d, sel, cfg_we, cfg_addr, cfg_wdata, cfg_restore,
    input  out, out_q, cfg_dirty
  );

  modport slave (
    input  d, sel, cfg_we, cfg_addr, cfg_wdata, cfg_restore,
    output out, out_q, cfg_dirty
  );
endinterface

// File: rtl/mux_4to1_lut_lut_store.sv
// -----------------------------------------------------------------------------
// mux_4to1_lut_lut_store
// The 64-entry single-bit table with its configuration logic.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset; loads the default table
//   i_we       in   write one entry this cycle
//   i_addr     in   entry index, {sel, d}
//   i_wdata    in   value written to the entry
//   i_restore  in   reload the default table this cycle (wins over i_we)
//   o_lut      out  full table contents, for the read mux
//   o_dirty    out  high once a write has landed since reset/restore
// -----------------------------------------------------------------------------
module mux_4to1_lut_lut_store
  import mux_4to1_lut_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic                   i_wdata,
  input  logic                   i_restore,
  output logic [LUT_ENTRIES-1:0] o_lut,
  output logic                   o_dirty
);

  logic [LUT_ENTRIES-1:0] r_lut;
  logic                   r_dirty;

  // Dirty tracks "a write happened", not "contents differ": rewriting an
  // entry with its current value still marks the table dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lut   <= DEFAULT_LUT;
      r_dirty <= 1'b0;
    end else if (i_restore) begin
      r_lut   <= DEFAULT_LUT;
      r_dirty <= 1'b0;
    end else if (i_we) begin
      r_lut[i_addr] <= i_wdata;
      r_dirty       <= 1'b1;
    end
  end

  assign o_lut   = r_lut;
  assign o_dirty = r_dirty;

endmodule

// File: rtl/mux_4to1_lut.sv
// -----------------------------------------------------------------------------
// mux_4to1_lut
// Reconfigurable 4:1 single-bit mux. The output is a lookup into a 64-entry
// table indexed by {sel, d}; out of reset the table implements out = d[sel],
// and individual entries can be rewritten at run time.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of mux_4to1_lut_if:
//            d, sel       in   lookup index
//            out          out  combinational lut[{sel,d}]
//            out_q        out  out registered on clk (0 in reset)
//            cfg_we/addr/wdata, cfg_restore  in  table programming
//            cfg_dirty    out  table written since reset/restore
// -----------------------------------------------------------------------------
module mux_4to1_lut
  import mux_4to1_lut_pkg::*;
#(
  parameter int LUT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_4to1_lut_if.slave     bus
);

  logic [LUT_DEPTH-1:0] w_lut;
  logic [ADDR_W-1:0]    w_idx;
  logic                 w_out;
  logic                 w_dirty;
  logic                 r_out_q;

  mux_4to1_lut_lut_store u_lut_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (bus.cfg_we),
    .i_addr    (bus.cfg_addr),
    .i_wdata   (bus.cfg_wdata),
    .i_restore (bus.cfg_restore),
    .o_lut     (w_lut),
    .o_dirty   (w_dirty)
  );

  // Read straight from the table registers: a write becomes visible right
  // after its edge, and the reset value shows without any clock.
  assign w_idx = {bus.sel, bus.d};
  assign w_out = w_lut[w_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= 1'b0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign bus.out       = w_out;
  assign bus.out_q     = r_out_q;
  assign bus.cfg_dirty = w_dirty;

endmodule

// File: tb/tb_mux_4to1_lut.sv
// -----------------------------------------------------------------------------
// tb_mux_4to1_lut
// Directed and randomized checks of mux_4to1_lut against a table model built
// from the rule "entry {s, dd} holds dd[s]", with expected out_q values
// queued one edge ahead.
// -----------------------------------------------------------------------------
module tb_mux_4to1_lut;

  logic clk;
  logic rst_n;

  mux_4to1_lut_if bus ();

  mux_4to1_lut u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [63:0] exp_lut;
  logic        exp_dirty;
  logic        exp_q[$];
  int          n_checks;
  int          n_fail;

  function automatic logic [63:0] ref_default();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) begin
      // data nibble shifted right by the select value, low bit kept
      v[i] = (((i % 16) >> (i / 16)) % 2) == 1;
    end
    return v;
  endfunction

  function automatic logic model_out();
    return exp_lut[{bus.sel, bus.d}];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idx(input logic [5:0] idx);
    bus.sel = idx[5:4];
    bus.d   = idx[3:0];
  endtask

  task automatic idle_cfg();
    bus.cfg_we      = 1'b0;
    bus.cfg_restore = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_wdata   = 1'b0;
  endtask

  // One rising edge with the inputs currently driven; updates the model and
  // checks the registered outputs just after the edge.
  task automatic cycle();
    logic pre_out;
    pre_out = model_out();
    @(posedge clk);
    if (!rst_n) begin
      exp_q.push_back(1'b0);
      exp_lut   = ref_default();
      exp_dirty = 1'b0;
    end else begin
      exp_q.push_back(pre_out);
      if (bus.cfg_restore) begin
        exp_lut   = ref_default();
        exp_dirty = 1'b0;
      end else if (bus.cfg_we) begin
        exp_lut[bus.cfg_addr] = bus.cfg_wdata;
        exp_dirty             = 1'b1;
      end
    end
    #1;
    check("out_q", bus.out_q, exp_q.pop_front());
    check("cfg_dirty", bus.cfg_dirty, exp_dirty);
  endtask

  task automatic write_entry(input logic [5:0] addr, input logic val);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = val;
    cycle();
    bus.cfg_we    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] a;
    logic       old_v;
    n_checks  = 0;
    n_fail    = 0;
    exp_lut   = ref_default();
    exp_dirty = 1'b0;
    rst_n     = 1'b0;
    idle_cfg();
    set_idx(6'd0);

    // reset state
    #2;
    check("rst_out_q", bus.out_q, 1'b0);
    check("rst_dirty", bus.cfg_dirty, 1'b0);
    check("rst_out", bus.out, 1'b0);

    // default function, combinational only: d=1010, sel 0..3 -> 0,1,0,1
    bus.d = 4'b1010;
    bus.sel = 2'd0; #10; check("dflt_sel0", bus.out, 1'b0);
    bus.sel = 2'd1; #10; check("dflt_sel1", bus.out, 1'b1);
    bus.sel = 2'd2; #10; check("dflt_sel2", bus.out, 1'b0);
    bus.sel = 2'd3; #10; check("dflt_sel3", bus.out, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive default sweep
    for (int i = 0; i < 64; i++) begin
      set_idx(6'(i));
      #1;
      check("sweep_out", bus.out, bus.d[bus.sel]);
      check("sweep_model", bus.out, model_out());
      cycle();
    end

    // reprogram one entry
    write_entry(6'b01_1010, 1'b0);
    set_idx(6'b01_1010); #1;
    check("prog_out", bus.out, 1'b0);
    check("prog_dirty", bus.cfg_dirty, 1'b1);
    set_idx(6'b11_1010); #1;
    check("prog_other", bus.out, 1'b1);
    cycle();

    // restore and write in the same cycle: restore wins
    bus.cfg_restore = 1'b1;
    write_entry(6'b00_0001, 1'b0);
    bus.cfg_restore = 1'b0;
    set_idx(6'b00_0001); #1;
    check("coll_entry", bus.out, 1'b1);
    check("coll_dirty", bus.cfg_dirty, 1'b0);
    set_idx(6'b01_1010); #1;
    check("coll_restored", bus.out, 1'b1);
    cycle();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      set_idx(6'($urandom_range(0, 63)));
      bus.cfg_we      = ($urandom_range(0, 3) == 0);
      bus.cfg_restore = ($urandom_range(0, 15) == 0);
      bus.cfg_addr    = 6'($urandom_range(0, 63));
      bus.cfg_wdata   = 1'($urandom_range(0, 1));
      #1;
      check("rand_out", bus.out, model_out());
      cycle();
    end
    idle_cfg();

    // read-during-write on the index being looked up
    a = 6'($urandom_range(0, 63));
    set_idx(a);
    #1;
    old_v = model_out();
    check("rdw_before", bus.out, old_v);
    write_entry(a, ~old_v);
    check("rdw_after", bus.out, ~old_v);
    cycle();
    check("rdw_out_q_new", bus.out_q, ~old_v);

    // async reset mid-operation
    write_entry(6'b01_1010, 1'b0);
    write_entry(6'b10_0000, 1'b1);
    set_idx(6'b01_1010); #1;
    check("pre_rst_out", bus.out, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_lut   = ref_default();
    exp_dirty = 1'b0;
    #1;
    check("arst_out", bus.out, 1'b1);
    check("arst_out_q", bus.out_q, 1'b0);
    check("arst_dirty", bus.cfg_dirty, 1'b0);
    set_idx(6'b10_0000); #1;
    check("arst_out2", bus.out, 1'b0);

    // writes while in reset are ignored
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 6'b00_0001;
    bus.cfg_wdata = 1'b0;
    cycle();
    cycle();
    idle_cfg();
    set_idx(6'b00_0001); #1;
    check("inrst_write", bus.out, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("post_rst_entry", bus.out, 1'b1);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
